mprj_pwr_monitor: RTL and testbench

MPRJ_PWR_MONITOR -- requirements
Module: mprj_pwr_monitor

---
 rtl/mprj_pwr_pkg.sv | 19 +
 rtl/mprj_pwr_debounce.sv | 51 +++++
 rtl/mprj_pwr_monitor.sv | 137 +++++++++++++
 tb/tb_mprj_pwr_monitor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_pwr_pkg.sv
// rtl/mprj_pwr_pkg.sv - shared constants and FSM state encoding for the user power monitor
//
// Contents:
//   CNT_W        width of the debounce and settle counters (8 bits, so both
//                limits can go up to 255)
//   pwr_state_t  power FSM state encoding, driven unchanged on pwr_state_o

package mprj_pwr_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ON    = 2'b10,
        ST_FAULT = 2'b11
    } pwr_state_t;

endpackage

// File: rtl/mprj_pwr_debounce.sv
// rtl/mprj_pwr_debounce.sv - two-flop synchronizer plus rise-only debounce for one user domain
//
// Ports:
//   clk         clock (management domain)
//   rst         synchronous active-high reset
//   vdd_logic1  level-shifted logic-high from the user domain, asynchronous to clk
//   powergood   debounced domain-good; rises DEBOUNCE_CYCLES+2 edges after the
//               input is first sampled high, falls 2 edges after it is sampled low

module mprj_pwr_debounce
    import mprj_pwr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic vdd_logic1,
    output logic powergood
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            cnt       <= '0;
            powergood <= 1'b0;
        end else begin
            sync_a <= vdd_logic1;
            sync_b <= sync_a;
            if (!sync_b) begin
                // Any synchronized low restarts the qualification and drops
                // powergood immediately; there is no debounce on the fall.
                cnt       <= '0;
                powergood <= 1'b0;
            end else begin
                // Counter parks at LIMIT, so it can never wrap back to zero.
                if (cnt != LIMIT) begin
                    cnt <= cnt + 1'b1;
                end
                powergood <= (cnt == LIMIT);
            end
        end
    end

endmodule

// File: rtl/mprj_pwr_monitor.sv
// rtl/mprj_pwr_monitor.sv - user-area power-good monitor and interface-enable sequencer
//
// Optional feature: define MPRJ_PWR_IRQ_EN to drive pwr_irq_o from the fault
// state; otherwise pwr_irq_o is tied low.
//
// Ports:
//   wb_clk_i             sole clock
//   wb_rst_i             synchronous active-high reset
//   mprj_vdd_logic1      user area 1 logic-high (asynchronous)
//   mprj2_vdd_logic1     user area 2 logic-high (asynchronous)
//   fault_clr_i          pulse that clears the fault state (ignored outside FAULT)
//   user1_vdd_powergood  debounced domain 1 good
//   user2_vdd_powergood  debounced domain 2 good
//   mprj_iface_ena       management-to-user interface enable, high only in ON
//   pwr_state_o          current FSM state (OFF=00 WAIT=01 ON=10 FAULT=11)
//   pwr_fault_o          sticky brown-out flag, high while in FAULT
//   pwr_irq_o            brown-out interrupt, level

module mprj_pwr_monitor
    import mprj_pwr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       mprj_vdd_logic1,
    input  logic       mprj2_vdd_logic1,
    input  logic       fault_clr_i,
    output logic       user1_vdd_powergood,
    output logic       user2_vdd_powergood,
    output logic       mprj_iface_ena,
    output logic [1:0] pwr_state_o,
    output logic       pwr_fault_o,
    output logic       pwr_irq_o
);

    // The settle counter counts edges already spent in WAIT; the edge that
    // sees SETTLE_CYCLES-1 is the SETTLE_CYCLES-th edge and moves to ON.
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    pwr_state_t       state;
    pwr_state_t       state_nxt;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] settle_cnt_nxt;
    logic             both_good;

    mprj_pwr_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb1 (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .vdd_logic1 (mprj_vdd_logic1),
        .powergood  (user1_vdd_powergood)
    );

    mprj_pwr_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb2 (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .vdd_logic1 (mprj2_vdd_logic1),
        .powergood  (user2_vdd_powergood)
    );

    assign both_good = user1_vdd_powergood & user2_vdd_powergood;

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        case (state)
            ST_OFF: begin
                if (both_good) begin
                    state_nxt      = ST_WAIT;
                    settle_cnt_nxt = '0;
                end
            end
            ST_WAIT: begin
                if (!both_good) begin
                    state_nxt = ST_OFF;
                end else if (settle_cnt >= SETTLE_LAST) begin
                    state_nxt = ST_ON;
                end else begin
                    settle_cnt_nxt = settle_cnt + 1'b1;
                end
            end
            ST_ON: begin
                // A power drop wins over a coincident fault_clr_i, and a
                // drop of both domains still lands in FAULT just once.
                if (!both_good) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (fault_clr_i) begin
                    state_nxt = ST_OFF;
                end
            end
            default: begin
                state_nxt = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_OFF;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    // Decoded straight from the state register so the enable falls on the
    // very edge the FSM leaves ON, including a reset edge.
    assign mprj_iface_ena = (state == ST_ON);
    assign pwr_fault_o    = (state == ST_FAULT);
    assign pwr_state_o    = state;

`ifdef MPRJ_PWR_IRQ_EN
    logic irq_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (state_nxt == ST_FAULT);
        end
    end

    assign pwr_irq_o = irq_q;
`else
    assign pwr_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_mprj_pwr_monitor.sv
// tb/tb_mprj_pwr_monitor.sv - self-checking bench for mprj_pwr_monitor against a behavioural model

module tb_mprj_pwr_monitor;

    localparam int D    = 16;
    localparam int S    = 8;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       l1  = 1'b0;
    logic       l2  = 1'b0;
    logic       clr = 1'b0;
    logic       pg1;
    logic       pg2;
    logic       ena;
    logic [1:0] st;
    logic       fault;
    logic       irq;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = -1;

    // Model: per-edge sampled input history, and the FSM kept as plain ints.
    bit smp1 [MAXC];
    bit smp2 [MAXC];
    bit m_pg1 = 1'b0;
    bit m_pg2 = 1'b0;
    int m_st  = 0;
    int m_wait = 0;

    always #5 clk = ~clk;

    mprj_pwr_monitor #(
        .DEBOUNCE_CYCLES(D),
        .SETTLE_CYCLES  (S)
    ) dut (
        .wb_clk_i            (clk),
        .wb_rst_i            (rst),
        .mprj_vdd_logic1     (l1),
        .mprj2_vdd_logic1    (l2),
        .fault_clr_i         (clr),
        .user1_vdd_powergood (pg1),
        .user2_vdd_powergood (pg2),
        .mprj_iface_ena      (ena),
        .pwr_state_o         (st),
        .pwr_fault_o         (fault),
        .pwr_irq_o           (irq)
    );

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    endtask

    // Powergood at edge n: the input was sampled high on each of the D+1
    // edges n-2-D .. n-2 (two synchronizer edges, then D qualifying edges).
    function automatic bit pg_window(input int n, input bit which);
        if (n - 2 - D < 0) return 1'b0;
        for (int k = n - 2 - D; k <= n - 2; k++) begin
            if (!(which ? smp2[k] : smp1[k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step();
        bit p1;
        bit p2;
        int exp_irq;
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d got=%0d exp=%0d", cyc, cyc, MAXC - 1);
            $fatal(1);
        end
        #1;
        p1 = m_pg1;
        p2 = m_pg2;
        smp1[cyc] = l1;
        smp2[cyc] = l2;
        if (rst) begin
            // Reset discards everything held in the synchronizers.
            smp1[cyc] = 1'b0;
            smp2[cyc] = 1'b0;
            if (cyc > 0) begin
                smp1[cyc-1] = 1'b0;
                smp2[cyc-1] = 1'b0;
            end
            m_pg1  = 1'b0;
            m_pg2  = 1'b0;
            m_st   = 0;
            m_wait = 0;
        end else begin
            m_pg1 = pg_window(cyc, 1'b0);
            m_pg2 = pg_window(cyc, 1'b1);
            case (m_st)
                0: if (p1 && p2) begin m_st = 1; m_wait = 0; end
                1: begin
                    if (!(p1 && p2)) m_st = 0;
                    else begin
                        m_wait++;
                        if (m_wait >= S) m_st = 2;
                    end
                end
                2: if (!(p1 && p2)) m_st = 3;
                default: if (clr) m_st = 0;
            endcase
        end
`ifdef MPRJ_PWR_IRQ_EN
        exp_irq = (m_st == 3) ? 1 : 0;
`else
        exp_irq = 0;
`endif
        chk("m_pg1",   pg1,   m_pg1);
        chk("m_pg2",   pg2,   m_pg2);
        chk("m_state", st,    m_st);
        chk("m_ena",   ena,   (m_st == 2) ? 1 : 0);
        chk("m_fault", fault, (m_st == 3) ? 1 : 0);
        chk("m_irq",   irq,   exp_irq);
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int exp_irq_on;
`ifdef MPRJ_PWR_IRQ_EN
        exp_irq_on = 1;
`else
        exp_irq_on = 0;
`endif
        // Reset state
        rst = 1'b1; l1 = 1'b0; l2 = 1'b0; clr = 1'b0;
        step_n(3);
        chk("rst_state", st, 0);
        chk("rst_ena",   ena, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pg1",   pg1, 0);

        // Power-up: both rise, sampled first at relative edge 0
        rst = 1'b0; l1 = 1'b1; l2 = 1'b1;
        step();
        step_n(17);
        chk("up_pg1_e17", pg1, 0);
        step();
        chk("up_pg1_e18", pg1, 1);
        chk("up_pg2_e18", pg2, 1);
        chk("up_st_e18",  st, 0);
        step();
        chk("up_st_e19",  st, 1);
        step_n(7);
        chk("up_ena_e26", ena, 0);
        step();
        chk("up_ena_e27", ena, 1);
        chk("up_st_e27",  st, 2);

        // Domain 2 brown-out in ON, with a coincident clear at the FAULT edge
        l2 = 1'b0;
        step();
        step();
        chk("bo_pg2_e1", pg2, 1);
        step();
        chk("bo_pg2_e2", pg2, 0);
        chk("bo_ena_e2", ena, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("bo_st_e3",    st, 3);
        chk("bo_ena_e3",   ena, 0);
        chk("bo_fault_e3", fault, 1);
        chk("bo_irq_e3",   irq, exp_irq_on);
        step_n(3);
        chk("bo_sticky", fault, 1);

        // Clear, ignored clear in OFF, then re-power domain 2
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_st",    st, 0);
        chk("clr_fault", fault, 0);
        chk("clr_irq",   irq, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ignored", st, 0);
        l2 = 1'b1;
        step();
        step_n(26);
        chk("rp_st_e26",  st, 1);
        chk("rp_ena_e26", ena, 0);
        step();
        chk("rp_ena_e27", ena, 1);

        // One-cycle reset while ON, inputs kept high
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_st",  st, 0);
        chk("mr_ena", ena, 0);
        chk("mr_pg1", pg1, 0);
        chk("mr_pg2", pg2, 0);
        step_n(27);
        chk("mr_st_r27", st, 1);
        step();
        chk("mr_st_r28", st, 2);

        // Glitch on domain 1 at relative edge 10 during ramp
        rst = 1'b1; l1 = 1'b0; l2 = 1'b0;
        step_n(2);
        rst = 1'b0; l1 = 1'b1; l2 = 1'b1;
        step();
        step_n(9);
        l1 = 1'b0;
        step();
        l1 = 1'b1;
        step_n(18);
        chk("gl_pg1_e28", pg1, 0);
        chk("gl_pg2_e28", pg2, 1);
        step();
        chk("gl_pg1_e29", pg1, 1);

        // Randomized operation against the model
        for (int i = 0; i < 4000; i++) begin
            if (l1) l1 = ($urandom_range(0, 119) != 0);
            else    l1 = ($urandom_range(0, 2) == 0);
            if (l2) l2 = ($urandom_range(0, 119) != 0);
            else    l2 = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
